phase_controller: RTL and testbench

//  Phase sequencer and run control for the 16-bit SIMPLE CPU core.

---
 rtl/simple_ctrl_pkg.sv | 19 +
 rtl/phase_controller_edge_rise.sv | 19 +
 rtl/phase_controller.sv | 128 ++++++++++++
 tb/tb_phase_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/simple_ctrl_pkg.sv
// Phase and run-state constants shared by the controller,
// reg_access and the decoder.
package simple_ctrl_pkg;

    localparam logic [2:0] PH_IDLE  = 3'b000;
    localparam logic [2:0] PH_FETCH = 3'b001;
    localparam logic [2:0] PH_REGRD = 3'b010;
    localparam logic [2:0] PH_EXEC  = 3'b011;
    localparam logic [2:0] PH_MEM   = 3'b100;
    localparam logic [2:0] PH_WB    = 3'b101;

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } run_state_e;

endpackage

// File: rtl/phase_controller_edge_rise.sv
// Rising-edge detector: registers the level and pulses
// for one cycle when it goes from 0 to 1.
module edge_rise (
    input  logic clock,
    input  logic reset,
    input  logic in_i,
    output logic pulse_o
);

    logic in_q;

    always_ff @(posedge clock) begin
        if (reset) in_q <= 1'b0;
        else       in_q <= in_i;
    end

    assign pulse_o = in_i & ~in_q;

endmodule

// File: rtl/phase_controller.sv
// Phase sequencer and run/stop/step/halt control for the
// SIMPLE CPU, with a retired-instruction counter.
module phase_controller
    import simple_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 exec_button,
    input  logic                 step_mode,
    input  logic                 halt_request,
    input  logic                 mem_wait,
    output logic [2:0]           phase_counter,
    output logic                 running,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE =
        {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    run_state_e           state_q;
    logic [2:0]           phase_q;
    logic                 running_q;
    logic                 halted_q;
    logic                 halt_pend_q;
    logic                 stop_pend_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 exec_edge;
    logic                 stop_req;

    edge_rise u_edge (
        .clock   (clock),
        .reset   (reset),
        .in_i    (exec_button),
        .pulse_o (exec_edge)
    );

    // A stop edge landing in writeback still ends this instruction.
    assign stop_req = stop_pend_q
                    | (exec_edge && state_q == ST_RUN)
                    | (state_q == ST_STEP);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_STOP;
            phase_q     <= PH_IDLE;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            halt_pend_q <= 1'b0;
            stop_pend_q <= 1'b0;
            cnt_q       <= '0;
        end else if (phase_q > PH_WB) begin
            state_q     <= ST_STOP;
            phase_q     <= PH_IDLE;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            halt_pend_q <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_STOP, ST_HALT: begin
                    if (exec_edge) begin
                        state_q   <= step_mode ? ST_STEP : ST_RUN;
                        phase_q   <= PH_FETCH;
                        running_q <= 1'b1;
                        halted_q  <= 1'b0;
                    end else begin
                        phase_q   <= PH_IDLE;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (exec_edge && state_q == ST_RUN)
                        stop_pend_q <= 1'b1;
                    unique case (phase_q)
                        PH_FETCH: phase_q <= PH_REGRD;
                        PH_REGRD: begin
                            phase_q <= PH_EXEC;
                            if (halt_request)
                                halt_pend_q <= 1'b1;
                        end
                        PH_EXEC: phase_q <= PH_MEM;
                        PH_MEM: begin
                            if (!mem_wait)
                                phase_q <= PH_WB;
                        end
                        PH_WB: begin
                            cnt_q <= cnt_q + CNT_ONE;
                            if (halt_pend_q) begin
                                state_q     <= ST_HALT;
                                phase_q     <= PH_IDLE;
                                running_q   <= 1'b0;
                                halted_q    <= 1'b1;
                                halt_pend_q <= 1'b0;
                                stop_pend_q <= 1'b0;
                            end else if (stop_req) begin
                                state_q     <= ST_STOP;
                                phase_q     <= PH_IDLE;
                                running_q   <= 1'b0;
                                stop_pend_q <= 1'b0;
                            end else begin
                                phase_q     <= PH_FETCH;
                            end
                        end
                        default: begin
                            state_q     <= ST_STOP;
                            phase_q     <= PH_IDLE;
                            running_q   <= 1'b0;
                            stop_pend_q <= 1'b0;
                            halt_pend_q <= 1'b0;
                        end
                    endcase
                end
                default: begin
                    state_q <= ST_STOP;
                    phase_q <= PH_IDLE;
                end
            endcase
        end
    end

    assign phase_counter = phase_q;
    assign running       = running_q;
    assign halted        = halted_q;
    assign instr_count   = cnt_q;

endmodule

// File: tb/tb_phase_controller.sv
// Directed bench for phase_controller: a vector table for
// free-running and stall behaviour, plus hand sequences.
module tb_phase_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        exec_b;
    logic        step_m;
    logic        halt_r;
    logic        mw;
    logic [2:0]  ph;
    logic        run;
    logic        hlt;
    logic [15:0] cnt;
    logic [2:0]  ph2;
    logic        run2;
    logic        hlt2;
    logic [1:0]  cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    phase_controller #(.CNT_WIDTH(16)) dut (
        .clock         (clk),
        .reset         (rst),
        .exec_button   (exec_b),
        .step_mode     (step_m),
        .halt_request  (halt_r),
        .mem_wait      (mw),
        .phase_counter (ph),
        .running       (run),
        .halted        (hlt),
        .instr_count   (cnt)
    );

    // Narrow counter copy to exercise wrap-around cheaply.
    phase_controller #(.CNT_WIDTH(2)) dut_w (
        .clock         (clk),
        .reset         (rst),
        .exec_button   (exec_b),
        .step_mode     (step_m),
        .halt_request  (halt_r),
        .mem_wait      (mw),
        .phase_counter (ph2),
        .running       (run2),
        .halted        (hlt2),
        .instr_count   (cnt2)
    );

    typedef struct {
        logic       ex;
        logic       hr;
        logic       mw;
        logic [2:0] ph;
        logic       run;
        logic       hlt;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic h,
                       input logic m, input logic [2:0] p,
                       input logic r, input logic hl,
                       input int c);
        vec_t v;
        v.ex = e; v.hr = h; v.mw = m;
        v.ph = p; v.run = r; v.hlt = hl; v.cnt = c;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got,
                       input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, got, exp);
        end
    endtask

    task automatic chk_st(input string nm,
                          input logic [2:0] p,
                          input logic r, input logic h,
                          input int c);
        chk({nm, ".phase"}, int'(ph), int'(p));
        chk({nm, ".running"}, int'(run), int'(r));
        chk({nm, ".halted"}, int'(hlt), int'(h));
        chk({nm, ".count"}, int'(cnt), c);
        chk({nm, ".count_w"}, int'(cnt2), c % 4);
    endtask

    task automatic do_reset();
        rst = 1'b1; exec_b = 1'b0; step_m = 1'b0;
        halt_r = 1'b0; mw = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_st("reset", 3'b000, 1'b0, 1'b0, 0);
    endtask

    task automatic pulse_start();
        exec_b = 1'b1;
        tick();
        exec_b = 1'b0;
    endtask

    initial begin
        // rows: exec, halt, mem_wait -> phase, run, halt, count
        add(1,0,0, 3'd1,1,0,0);
        add(1,0,0, 3'd2,1,0,0);
        add(0,0,0, 3'd3,1,0,0);
        add(0,0,0, 3'd4,1,0,0);
        add(0,0,0, 3'd5,1,0,0);
        add(0,0,0, 3'd1,1,0,1);
        add(0,0,0, 3'd2,1,0,1);
        add(0,0,0, 3'd3,1,0,1);
        add(0,0,0, 3'd4,1,0,1);
        add(0,0,0, 3'd5,1,0,1);
        add(0,0,0, 3'd1,1,0,2);
        add(0,0,0, 3'd2,1,0,2);
        add(0,0,0, 3'd3,1,0,2);
        add(0,0,0, 3'd4,1,0,2);
        add(0,0,0, 3'd5,1,0,2);
        add(0,0,0, 3'd1,1,0,3);
        add(0,1,0, 3'd2,1,0,3);
        add(0,0,1, 3'd3,1,0,3);
        add(0,0,1, 3'd4,1,0,3);
        add(0,0,1, 3'd4,1,0,3);
        add(0,0,1, 3'd4,1,0,3);
        add(0,0,1, 3'd4,1,0,3);
        add(0,0,1, 3'd4,1,0,3);
        add(0,0,0, 3'd5,1,0,3);
        add(0,0,0, 3'd1,1,0,4);
        add(0,0,0, 3'd2,1,0,4);

        do_reset();
        foreach (tbl[i]) begin
            exec_b = tbl[i].ex;
            halt_r = tbl[i].hr;
            mw     = tbl[i].mw;
            tick();
            chk_st($sformatf("vec%0d", i), tbl[i].ph,
                   tbl[i].run, tbl[i].hlt, tbl[i].cnt);
        end

        // halt in regread of the second instruction
        do_reset();
        pulse_start();
        repeat (5) tick();
        chk_st("h.i2", 3'd1, 1'b1, 1'b0, 1);
        tick();
        halt_r = 1'b1;
        tick();
        halt_r = 1'b0;
        tick();
        tick();
        chk_st("h.wb", 3'd5, 1'b1, 1'b0, 1);
        tick();
        chk_st("h.halt", 3'd0, 1'b0, 1'b1, 2);
        tick();
        chk_st("h.hold", 3'd0, 1'b0, 1'b1, 2);
        pulse_start();
        chk_st("h.resume", 3'd1, 1'b1, 1'b0, 2);

        // single step, step_mode change mid-run ignored
        do_reset();
        step_m = 1'b1;
        pulse_start();
        step_m = 1'b0;
        repeat (4) tick();
        chk_st("s.wb", 3'd5, 1'b1, 1'b0, 0);
        tick();
        chk_st("s.stop", 3'd0, 1'b0, 1'b0, 1);
        tick();
        chk_st("s.idle", 3'd0, 1'b0, 1'b0, 1);
        step_m = 1'b1;
        pulse_start();
        repeat (5) tick();
        chk_st("s.stop2", 3'd0, 1'b0, 1'b0, 2);

        // halt and stop both pending: halt wins
        do_reset();
        pulse_start();
        tick();
        halt_r = 1'b1;
        tick();
        halt_r = 1'b0;
        exec_b = 1'b1;
        tick();
        exec_b = 1'b0;
        tick();
        tick();
        chk_st("hs.halt", 3'd0, 1'b0, 1'b1, 1);
        // stop request alone
        pulse_start();
        tick();
        tick();
        exec_b = 1'b1;
        tick();
        exec_b = 1'b0;
        tick();
        chk_st("st.wb", 3'd5, 1'b1, 1'b0, 1);
        tick();
        chk_st("st.stop", 3'd0, 1'b0, 1'b0, 2);

        // reset during a memory stall
        do_reset();
        pulse_start();
        mw = 1'b1;
        repeat (4) tick();
        chk_st("r.stall", 3'd4, 1'b1, 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mw = 1'b0;
        chk_st("r.rst", 3'd0, 1'b0, 1'b0, 0);
        tick();
        chk_st("r.after", 3'd0, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
